// File: rtl/mtsp_sf_rcp_nr.sv
`timescale 1ns/1ps
// mtsp_sf_rcp_nr
//   FP32 reciprocal for the MTSP special-function unit. It classifies special
//   operands, indexes an external registered seed LUT, refines the seed with
//   one Newton-Raphson step and packs an FP32 result. The pipeline is three
//   entries deep (S1 -> S2 -> OUT) with valid/ready flow control and full
//   backpressure.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   IN_VALID/IN_READY    operand handshake; IN_A is the FP32 operand and
//                        IN_TAG is sideband carried unmodified
//   LUT_INDEX            seed LUT address (LUT answers one cycle later)
//   LUT_REF              LUT word: [22:16] seed bits ref7, [15:0] seed^2 (0.16)
//   OUT_VALID/OUT_READY  result handshake; OUT_DATA is FP32 1/x, OUT_TAG is its tag
module mtsp_sf_rcp_nr #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_A,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic [7:0]       LUT_INDEX,
  input  logic [22:0]      LUT_REF,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_DATA,
  output logic [TAG_W-1:0] OUT_TAG
);

  // Operand class decided at accept time. INF/ZERO name the input class.
  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_INF,
    CLS_ZERO,
    CLS_POW2,
    CLS_NORM
  } cls_e;

  // S1: operand, class (its frac[22:15] doubles as the LUT index register)
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [7:0]       s1_exp_q;
  logic [22:0]      s1_frac_q;
  cls_e             s1_cls_q;
  logic [TAG_W-1:0] s1_tag_q;
  // S2: packed result
  logic             s2_valid_q;
  logic [31:0]      s2_data_q;
  logic [TAG_W-1:0] s2_tag_q;
  // OUT register
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             out_free;
  logic             s2_free;
  logic             s1_free;
  logic             accept;
  cls_e             cls_d;
  logic [8:0]       seed9;
  logic [39:0]      prod;
  logic [24:0]      p;
  logic [25:0]      r1;
  logic [22:0]      mant;
  logic [7:0]       exp_pow2;
  logic [7:0]       exp_norm;
  logic [31:0]      s2_data_d;

  // Each stage loads when empty or when its contents move on.
  assign out_free  = !out_valid_q || OUT_READY;
  assign s2_free   = !s2_valid_q || out_free;
  assign s1_free   = !s1_valid_q || s2_free;
  assign IN_READY  = s1_free;
  assign accept    = IN_VALID && s1_free;

  // The LUT is registered, so while S1 is stalled we keep re-reading its own
  // index; LUT_REF therefore always belongs to the operand sitting in S1.
  assign LUT_INDEX = accept ? IN_A[22:15] : s1_frac_q[22:15];

  always_comb begin
    cls_d = CLS_NORM;
    if (&IN_A[30:23]) begin
      cls_d = (|IN_A[22:0]) ? CLS_NAN : CLS_INF;
    end else if (~|IN_A[30:23]) begin
      cls_d = CLS_ZERO;
    end else if (~|IN_A[22:0]) begin
      cls_d = CLS_POW2;
    end
  end

  // r1 = 2*r0 - m*r0^2 in 24 fractional bits. The LUT drops the seed's top
  // two bits: bit 8 is always 1 and bit 7 is set exactly for index <= 85.
  always_comb begin
    seed9 = {1'b1, (s1_frac_q[22:15] <= 8'd85), LUT_REF[22:16]};
    prod  = 40'({1'b1, s1_frac_q}) * 40'(LUT_REF[15:0]);
    p     = 25'(prod >> 15);
    r1    = {1'b0, seed9, 16'd0} - {1'b0, p};
    // Clamp to [2^23, 2^24-1]; bit 25 flags a negative difference.
    if (r1[25]) begin
      mant = '0;
    end else if (r1[24]) begin
      mant = '1;
    end else if (!r1[23]) begin
      mant = '0;
    end else begin
      mant = r1[22:0];
    end
  end

  always_comb begin
    exp_pow2  = 8'd254 - s1_exp_q;
    exp_norm  = 8'd253 - s1_exp_q;
    s2_data_d = '0;
    case (s1_cls_q)
      CLS_NAN:  s2_data_d = 32'h7FC0_0000;
      CLS_INF:  s2_data_d = {s1_sign_q, 31'd0};
      CLS_ZERO: s2_data_d = {s1_sign_q, 8'hFF, 23'd0};
      CLS_POW2: s2_data_d = (s1_exp_q >= 8'd254) ? {s1_sign_q, 31'd0}
                                                  : {s1_sign_q, exp_pow2, 23'd0};
      default:  s2_data_d = (s1_exp_q >= 8'd253) ? {s1_sign_q, 31'd0}
                                                  : {s1_sign_q, exp_norm, mant};
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_cls_q    <= CLS_NAN;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      if (s1_free) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_sign_q <= IN_A[31];
          s1_exp_q  <= IN_A[30:23];
          s1_frac_q <= IN_A[22:0];
          s1_cls_q  <= cls_d;
          s1_tag_q  <= IN_TAG;
        end
      end
      if (s2_free) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
          s2_tag_q  <= s1_tag_q;
        end
      end
      if (out_free) begin
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_data_q <= s2_data_q;
          out_tag_q  <= s2_tag_q;
        end
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_TAG   = out_tag_q;

endmodule

// File: tb/tb_mtsp_sf_rcp_nr.sv
`timescale 1ns/1ps
// Self-checking bench for mtsp_sf_rcp_nr: a behavioural seed LUT, a reference
// reciprocal model and an in-order scoreboard sampled on the falling edge.
module tb_mtsp_sf_rcp_nr;
  localparam int TAG_W = 4;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [31:0]      IN_A = '0;
  logic [TAG_W-1:0] IN_TAG = '0;
  logic [7:0]       LUT_INDEX;
  logic [22:0]      LUT_REF = '0;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b1;
  logic [31:0]      OUT_DATA;
  logic [TAG_W-1:0] OUT_TAG;

  mtsp_sf_rcp_nr #(.TAG_W(TAG_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_TAG(IN_TAG),
    .LUT_INDEX(LUT_INDEX), .LUT_REF(LUT_REF),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_TAG(OUT_TAG)
  );

  always #5 CLK = ~CLK;

  // Seed table: seed9 ~ 512/(1+(i+0.5)/256), seed^2 truncated to 0.16.
  int          seed_tab[256];
  logic [22:0] rom[256];
  always @(posedge CLK) LUT_REF <= rom[LUT_INDEX];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rcp(input logic [31:0] a);
    logic   s;
    int     e;
    longint f, m, sd, sq, p, r1;
    s = a[31];
    e = int'(a[30:23]);
    f = longint'(a[22:0]);
    if (e == 255) return (f != 0) ? 32'h7FC0_0000 : {s, 31'd0};
    if (e == 0) return {s, 8'hFF, 23'd0};
    if (f == 0) begin
      if (254 - e <= 0) return {s, 31'd0};
      return {s, 8'(254 - e), 23'd0};
    end
    if (e >= 253) return {s, 31'd0};
    sd = longint'(seed_tab[int'(a[22:15])]);
    sq = (sd * sd) / 4;
    m  = 8388608 + f;
    p  = (m * sq) / 32768;
    r1 = sd * 65536 - p;
    if (r1 >= 16777216) r1 = 16777215;
    if (r1 < 8388608) r1 = 8388608;
    return {s, 8'(253 - e), 23'(r1 - 8388608)};
  endfunction

  function automatic logic [31:0] rand_norm();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(1, 252));
    v[22:0]  = 23'($urandom_range(1, 8388607));
    return v;
  endfunction

  // Scoreboard / monitor. Inputs and OUT_READY only change 1ns after a rising
  // edge, so the falling edge sees exactly what the next rising edge will do.
  logic [TAG_W+31:0] exp_q[$];
  logic [31:0]       got_q[$];
  int                drain_cyc[$];
  int                cyc = 0;
  logic [7:0]        last_idx = '0;
  logic [TAG_W+31:0] ex;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (nRST) begin
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'(OUT_VALID), 64'd0);
        end else begin
          ex = exp_q.pop_front();
          check_eq("out_data", 64'(OUT_DATA), 64'(ex[31:0]));
          check_eq("out_tag", 64'(OUT_TAG), 64'(ex[TAG_W+31:32]));
          got_q.push_back(OUT_DATA);
          drain_cyc.push_back(cyc);
        end
      end
      if (IN_VALID && IN_READY) begin
        exp_q.push_back({IN_TAG, ref_rcp(IN_A)});
        check_eq("lut_idx_accept", 64'(LUT_INDEX), 64'(IN_A[22:15]));
        last_idx = IN_A[22:15];
      end else if (!IN_READY) begin
        check_eq("lut_idx_stall", 64'(LUT_INDEX), 64'(last_idx));
      end
    end
  end

  // OUT_READY policy: 0 = always ready, 1 = random, 2 = never ready
  int rdy_mode = 0;
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = 1'($urandom_range(0, 1));
      default: OUT_READY = 1'b0;
    endcase
  end

  // Call right after a rising edge; returns right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [TAG_W-1:0] t);
    bit ok = 1'b0;
    #1;
    IN_VALID = 1'b1;
    IN_A     = a;
    IN_TAG   = t;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge CLK);
      if (IN_READY) ok = 1'b1;
      @(posedge CLK);
    end
    check_eq("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic idle();
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge CLK);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge CLK);
  endtask

  // Accept at edge E with an empty pipe: OUT_VALID must rise only after E+2.
  task automatic lat_test(input logic [31:0] a, input logic [TAG_W-1:0] t,
                          input logic [7:0] idx, input logic [31:0] expd);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b1;
    IN_A     = a;
    IN_TAG   = t;
    #1;
    check_eq("lat_in_ready", 64'(IN_READY), 64'd1);
    check_eq("lat_lut_index", 64'(LUT_INDEX), 64'(idx));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    check_eq("lat_e0_valid", 64'(OUT_VALID), 64'd0);
    @(posedge CLK);
    #1;
    check_eq("lat_e1_valid", 64'(OUT_VALID), 64'd0);
    @(posedge CLK);
    #1;
    check_eq("lat_e2_valid", 64'(OUT_VALID), 64'd1);
    check_eq("lat_e2_data", 64'(OUT_DATA), 64'(expd));
    check_eq("lat_e2_tag", 64'(OUT_TAG), 64'(t));
  endtask

  logic [31:0] dir_in[11]  = '{32'h3F80_0000, 32'h4000_0000, 32'hBFC0_0000, 32'h7FC1_2345,
                               32'hFF80_0000, 32'h0000_0001, 32'h8000_0000,
                               32'h7E80_0000, 32'h7F00_0000, 32'h7E90_0000, 32'h0080_0000};
  // 1/2^-126 = 2^126, biased exponent 253
  logic [31:0] dir_out[11] = '{32'h3F80_0000, 32'h3F00_0000, 32'hBF2A_AB00, 32'h7FC0_0000,
                               32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                               32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 32'h7E80_0000};

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          acc;
    real         x, y, err;
    logic [31:0] g;

    for (int i = 0; i < 256; i++) begin
      seed_tab[i] = $rtoi(131072.0 / (real'(i) + 256.5) + 0.5);
      rom[i]      = {7'(seed_tab[i] % 128), 16'((seed_tab[i] * seed_tab[i]) / 4)};
    end

    // Reset held with a valid operand presented
    nRST     = 1'b0;
    IN_VALID = 1'b1;
    IN_A     = 32'h3FC0_0000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check_eq("rst_out_data", 64'(OUT_DATA), 64'd0);
    check_eq("rst_out_tag", 64'(OUT_TAG), 64'd0);
    IN_VALID = 1'b0;
    #2 nRST = 1'b1;

    // First operand: 1.5 -> 2/3
    lat_test(32'h3FC0_0000, 4'd3, 8'h80, 32'h3F2A_AB00);
    wait_empty();

    // Directed specials and exponent limits, back-to-back
    got_q.delete();
    drain_cyc.delete();
    for (int i = 0; i < 11; i++) send(dir_in[i], 4'(i));
    idle();
    wait_empty();
    check_eq("dir_count", 64'(got_q.size()), 64'd11);
    for (int i = 0; i < 11 && i < got_q.size(); i++) check_eq("dir_value", 64'(got_q[i]), 64'(dir_out[i]));
    if (drain_cyc.size() == 11) check_eq("dir_consecutive", 64'(drain_cyc[10] - drain_cyc[0]), 64'd10);

    // Stall depth: consumer never ready, pipeline must take exactly 3
    rdy_mode = 2;
    @(posedge CLK);
    #1;
    acc      = 0;
    IN_VALID = 1'b1;
    IN_A     = rand_norm();
    IN_TAG   = 4'd0;
    repeat (8) begin
      @(negedge CLK);
      if (IN_READY) begin
        acc++;
        @(posedge CLK);
        #1;
        IN_A   = rand_norm();
        IN_TAG = IN_TAG + 4'd1;
      end else begin
        @(posedge CLK);
      end
    end
    check_eq("stall_depth", 64'(acc), 64'd3);
    #1;
    check_eq("in_ready_stalled", 64'(IN_READY), 64'd0);
    IN_VALID = 1'b0;

    // Random backpressure on 8 random normals, then a mixed random stream
    rdy_mode = 1;
    @(posedge CLK);
    for (int i = 0; i < 8; i++) send(rand_norm(), 4'(i));
    for (int i = 0; i < 40; i++) send($urandom(), 4'($urandom_range(0, 15)));
    idle();
    rdy_mode = 0;
    wait_empty();

    // Index sweep at bucket midpoints, bit-exact plus accuracy bound
    got_q.delete();
    for (int i = 0; i < 256; i++) send({1'b0, 8'd127, 23'((i << 15) | 'h4000)}, 4'(i));
    idle();
    wait_empty();
    check_eq("sweep_count", 64'(got_q.size()), 64'd256);
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      g   = got_q[i];
      x   = 1.0 + real'((i << 15) | 'h4000) / 8388608.0;
      y   = (1.0 + real'(g[22:0]) / 8388608.0) * 0.5;
      err = y * x - 1.0;
      if (err < 0.0) err = -err;
      check_eq("sweep_relerr_ok", 64'(err < (1.0 / 8192.0)), 64'd1);
    end

    // Reset with three operands in flight
    rdy_mode = 2;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) send(rand_norm(), 4'(i + 5));
    idle();
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    exp_q.delete();
    #1;
    check_eq("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    check_eq("mid_rst_data", 64'(OUT_DATA), 64'd0);
    check_eq("mid_rst_tag", 64'(OUT_TAG), 64'd0);
    check_eq("mid_rst_in_ready", 64'(IN_READY), 64'd1);
    rdy_mode = 0;
    @(negedge CLK);
    #2 nRST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check_eq("post_rst_no_stale", 64'(OUT_VALID), 64'd0);
    lat_test(32'h4000_0000, 4'd9, 8'h00, 32'h3F00_0000);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
